// File: rtl/uart_msg_parser.sv
// Receive-side message framer: $ + 3-char type + '-' + payload + '#'.
// Streams payload bytes tagged with the decoded type and reports start, done, length and errors.
module uart_msg_parser #(
    parameter int unsigned MAX_PAYLOAD    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter logic [7:0]  SOF            = 8'h24,
    parameter logic [7:0]  SEP            = 8'h2D,
    parameter logic [7:0]  EOF            = 8'h23
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic [1:0] msg_type,
    output logic       msg_start,
    output logic       msg_done,
    output logic [7:0] msg_len,
    output logic       msg_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned CW = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PAYLOAD);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TYPE0    = 3'd1;
    localparam logic [2:0] TYPE1    = 3'd2;
    localparam logic [2:0] TYPE2    = 3'd3;
    localparam logic [2:0] SEP_WAIT = 3'd4;
    localparam logic [2:0] PAYLOAD  = 3'd5;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_RDM  = 2'd1;
    localparam logic [1:0] T_RPM  = 2'd2;
    localparam logic [1:0] T_SLM  = 2'd3;

    localparam logic [1:0] E_FRAME = 2'd0;
    localparam logic [1:0] E_TYPE  = 2'd1;
    localparam logic [1:0] E_OVFL  = 2'd2;
    localparam logic [1:0] E_TMO   = 2'd3;

    logic [2:0]    state_q, state_d;
    logic [7:0]    id0_q, id0_d, id1_q, id1_d;
    logic [1:0]    type_q, type_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    pl_data_q, pl_data_d;
    logic          pl_valid_q, pl_valid_d;
    logic [1:0]    msg_type_q, msg_type_d;
    logic          msg_start_q, msg_start_d;
    logic          msg_done_q, msg_done_d;
    logic [7:0]    msg_len_q, msg_len_d;
    logic          msg_err_q, msg_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          busy_q, busy_d;
    logic [1:0]    id_dec;

    // Type decode uses the live third character so the match lands with it
    always_comb begin
        id_dec = T_NONE;
        if ({id0_q, id1_q, rx_data} == "RDM") id_dec = T_RDM;
        if ({id0_q, id1_q, rx_data} == "RPM") id_dec = T_RPM;
        if ({id0_q, id1_q, rx_data} == "SLM") id_dec = T_SLM;
    end

    always_comb begin
        state_d     = state_q;
        id0_d       = id0_q;
        id1_d       = id1_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        pl_data_d   = pl_data_q;
        pl_valid_d  = 1'b0;
        msg_start_d = 1'b0;
        msg_done_d  = 1'b0;
        msg_len_d   = msg_len_q;
        msg_err_d   = 1'b0;
        err_code_d  = err_code_q;
        msg_type_d  = T_NONE;

        if (rx_valid) begin
            tmo_d = '0;
            if (state_q != IDLE && rx_data == SOF) begin
                // Resync: this SOF opens the next frame
                msg_err_d  = 1'b1;
                err_code_d = E_FRAME;
                state_d    = TYPE0;
            end else begin
                case (state_q)
                    IDLE:  if (rx_data == SOF) state_d = TYPE0;
                    TYPE0: begin id0_d = rx_data; state_d = TYPE1; end
                    TYPE1: begin id1_d = rx_data; state_d = TYPE2; end
                    TYPE2: begin
                        if (id_dec != T_NONE) begin
                            type_d  = id_dec;
                            state_d = SEP_WAIT;
                        end else begin
                            msg_err_d  = 1'b1;
                            err_code_d = E_TYPE;
                            state_d    = IDLE;
                        end
                    end
                    SEP_WAIT: begin
                        if (rx_data == SEP) begin
                            msg_start_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = PAYLOAD;
                        end else begin
                            msg_err_d  = 1'b1;
                            err_code_d = E_FRAME;
                            state_d    = IDLE;
                        end
                    end
                    PAYLOAD: begin
                        if (rx_data == EOF) begin
                            msg_done_d = 1'b1;
                            msg_len_d  = 8'(cnt_q);
                            state_d    = IDLE;
                        end else if (cnt_q == CNT_MAX) begin
                            msg_err_d  = 1'b1;
                            err_code_d = E_OVFL;
                            state_d    = IDLE;
                        end else begin
                            pl_valid_d = 1'b1;
                            pl_data_d  = rx_data;
                            cnt_d      = cnt_q + CW'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                msg_err_d  = 1'b1;
                err_code_d = E_TMO;
                tmo_d      = '0;
                state_d    = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end

        // Type is visible from msg_start through the terminating pulse only
        if (state_d == PAYLOAD)      msg_type_d = type_q;
        else if (state_q == PAYLOAD) msg_type_d = msg_type_q;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id0_q       <= '0;
            id1_q       <= '0;
            type_q      <= T_NONE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            pl_data_q   <= '0;
            pl_valid_q  <= 1'b0;
            msg_type_q  <= T_NONE;
            msg_start_q <= 1'b0;
            msg_done_q  <= 1'b0;
            msg_len_q   <= '0;
            msg_err_q   <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id0_q       <= id0_d;
            id1_q       <= id1_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            pl_data_q   <= pl_data_d;
            pl_valid_q  <= pl_valid_d;
            msg_type_q  <= msg_type_d;
            msg_start_q <= msg_start_d;
            msg_done_q  <= msg_done_d;
            msg_len_q   <= msg_len_d;
            msg_err_q   <= msg_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    assign pl_data   = pl_data_q;
    assign pl_valid  = pl_valid_q;
    assign msg_type  = msg_type_q;
    assign msg_start = msg_start_q;
    assign msg_done  = msg_done_q;
    assign msg_len   = msg_len_q;
    assign msg_err   = msg_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_msg_parser.sv
// Directed bench for uart_msg_parser: byte table with expected responses plus
// hand-written timeout and reset sequences.
module tb_uart_msg_parser;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic [1:0] msg_type;
    logic       msg_start;
    logic       msg_done;
    logic [7:0] msg_len;
    logic       msg_err;
    logic [1:0] err_code;
    logic       busy;

    uart_msg_parser #(
        .MAX_PAYLOAD   (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .msg_type (msg_type),
        .msg_start(msg_start),
        .msg_done (msg_done),
        .msg_len  (msg_len),
        .msg_err  (msg_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct packed {
        logic       pv;
        logic [7:0] pd;
        logic [1:0] typ;
        logic       st;
        logic       dn;
        logic [7:0] len;
        logic       er;
        logic [1:0] code;
        logic       busy;
    } out_t;

    typedef struct {
        string      tag;
        logic [7:0] d;
        out_t       e;
    } rec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] hold_len  = 8'd0;
    logic [1:0] hold_code = 2'd0;
    string      tag;
    rec_t       tbl[$];

    function automatic rec_t mk(logic [7:0] d, logic pv, logic [1:0] typ, logic st, logic dn,
                                logic [7:0] len, logic er, logic [1:0] code, logic bsy);
        rec_t r;
        r.tag    = tag;
        r.d      = d;
        r.e      = '0;
        r.e.pv   = pv;
        r.e.pd   = pv ? d : 8'h00;
        r.e.typ  = typ;
        r.e.st   = st;
        r.e.dn   = dn;
        r.e.len  = len;
        r.e.er   = er;
        r.e.code = code;
        r.e.busy = bsy;
        return r;
    endfunction

    function automatic rec_t hdr(logic [7:0] d);                 return mk(d, 0, 0, 0, 0, 0, 0, 0, 1); endfunction
    function automatic rec_t ign(logic [7:0] d);                 return mk(d, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic rec_t st(logic [7:0] d, logic [1:0] t);   return mk(d, 0, t, 1, 0, 0, 0, 0, 1); endfunction
    function automatic rec_t pl(logic [7:0] d, logic [1:0] t);   return mk(d, 1, t, 0, 0, 0, 0, 0, 1); endfunction
    function automatic rec_t dn(logic [7:0] d, logic [1:0] t, logic [7:0] l);
        return mk(d, 0, t, 0, 1, l, 0, 0, 0);
    endfunction
    function automatic rec_t er(logic [7:0] d, logic [1:0] t, logic [1:0] c, logic b);
        return mk(d, 0, t, 0, 0, 0, 1, c, b);
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("pv=%0b pd=%02h typ=%0d st=%0b dn=%0b len=%0d er=%0b code=%0d busy=%0b",
                         o.pv, o.pd, o.typ, o.st, o.dn, o.len, o.er, o.code, o.busy);
    endfunction

    task automatic check(input string name, input out_t exp, input bit mask_pd);
        out_t act, m;
        act = '{pl_valid, pl_data, msg_type, msg_start, msg_done, msg_len, msg_err, err_code, busy};
        m   = '1;
        if (mask_pd && !exp.pv) m.pd = 8'h00;
        checks++;
        if (((act ^ exp) & m) != '0) begin
            failures++;
            $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    // Expected outputs on an idle cycle following a response with flags e
    function automatic out_t quiet(out_t e);
        out_t q;
        q      = '0;
        q.typ  = (e.dn || e.er) ? 2'd0 : e.typ;
        q.busy = e.busy;
        q.len  = hold_len;
        q.code = hold_code;
        return q;
    endfunction

    function automatic out_t resolve(out_t e);
        out_t x;
        x = e;
        if (e.dn) hold_len  = e.len;
        if (e.er) hold_code = e.code;
        x.len  = hold_len;
        x.code = hold_code;
        return x;
    endfunction

    // One byte, its response next cycle, then two idle cycles (4-cycle byte spacing)
    task automatic apply_row(input rec_t r, input string name);
        @(negedge clk_50M);
        rx_valid = 1'b1;
        rx_data  = r.d;
        @(negedge clk_50M);
        rx_valid = 1'b0;
        check(name, resolve(r.e), 1'b1);
        repeat (2) begin
            @(negedge clk_50M);
            check({name, "_gap"}, quiet(r.e), 1'b1);
        end
    endtask

    task automatic send_hdr(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                            input logic [1:0] t, input string name);
        apply_row(hdr("$"), name);
        apply_row(hdr(c1), name);
        apply_row(hdr(c2), name);
        apply_row(hdr(c3), name);
        apply_row(st("-", t), name);
    endtask

    initial begin
        rec_t r;
        out_t e;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        tag = "rpm";
        tbl.push_back(hdr("$")); tbl.push_back(hdr("R")); tbl.push_back(hdr("P")); tbl.push_back(hdr("M"));
        tbl.push_back(st("-", 2)); tbl.push_back(pl("A", 2)); tbl.push_back(pl("B", 2));
        tbl.push_back(dn("#", 2, 2));
        tag = "slm_empty";
        tbl.push_back(hdr("$")); tbl.push_back(hdr("S")); tbl.push_back(hdr("L")); tbl.push_back(hdr("M"));
        tbl.push_back(st("-", 3)); tbl.push_back(dn("#", 3, 0));
        tag = "bad_type";
        tbl.push_back(hdr("$")); tbl.push_back(hdr("R")); tbl.push_back(hdr("X"));
        tbl.push_back(er("M", 0, 1, 0)); tbl.push_back(ign("-"));
        tag = "bad_sep";
        tbl.push_back(hdr("$")); tbl.push_back(hdr("S")); tbl.push_back(hdr("L")); tbl.push_back(hdr("M"));
        tbl.push_back(er("X", 0, 0, 0));
        tag = "overflow";
        tbl.push_back(hdr("$")); tbl.push_back(hdr("R")); tbl.push_back(hdr("D")); tbl.push_back(hdr("M"));
        tbl.push_back(st("-", 1));
        tbl.push_back(pl("1", 1)); tbl.push_back(pl("2", 1)); tbl.push_back(pl("3", 1)); tbl.push_back(pl("4", 1));
        tbl.push_back(er("5", 1, 2, 0)); tbl.push_back(ign("#"));
        tag = "resync";
        tbl.push_back(hdr("$")); tbl.push_back(hdr("R")); tbl.push_back(hdr("D")); tbl.push_back(hdr("M"));
        tbl.push_back(st("-", 1)); tbl.push_back(pl("A", 1)); tbl.push_back(pl("B", 1));
        tbl.push_back(er("$", 1, 0, 1));
        tbl.push_back(hdr("S")); tbl.push_back(hdr("L")); tbl.push_back(hdr("M"));
        tbl.push_back(st("-", 3)); tbl.push_back(pl("C", 3)); tbl.push_back(dn("#", 3, 1));

        #12;
        check("reset", '0, 1'b0);
        @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);
        check("after_reset", '0, 1'b0);

        foreach (tbl[i]) apply_row(tbl[i], $sformatf("%s_%0d", tbl[i].tag, i));

        // Silence after a payload byte: error on the 16th idle cycle's response
        tag = "timeout";
        send_hdr("R", "P", "M", 2, "timeout_hdr");
        @(negedge clk_50M);
        rx_valid = 1'b1;
        rx_data  = "A";
        @(negedge clk_50M);
        rx_valid = 1'b0;
        r = pl("A", 2);
        check("timeout_A", resolve(r.e), 1'b1);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_50M);
            check($sformatf("timeout_wait_%0d", k), quiet(r.e), 1'b1);
        end
        @(negedge clk_50M);
        r = er("A", 2, 3, 0);
        check("timeout_err", resolve(r.e), 1'b1);
        @(negedge clk_50M);
        check("timeout_after", quiet(r.e), 1'b1);

        // Next byte arrives on the terminal cycle: processed, no timeout
        send_hdr("R", "P", "M", 2, "term_hdr");
        @(negedge clk_50M);
        rx_valid = 1'b1;
        rx_data  = "A";
        @(negedge clk_50M);
        rx_valid = 1'b0;
        r = pl("A", 2);
        check("term_A", resolve(r.e), 1'b1);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_50M);
            check($sformatf("term_wait_%0d", k), quiet(r.e), 1'b1);
            if (k == 15) begin
                rx_valid = 1'b1;
                rx_data  = "B";
            end
        end
        @(negedge clk_50M);
        rx_valid = 1'b0;
        r = pl("B", 2);
        check("term_B", resolve(r.e), 1'b1);
        apply_row(dn("#", 2, 2), "term_done");
        r = ign("x");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_50M);
            check($sformatf("idle_no_timeout_%0d", k), quiet(r.e), 1'b1);
        end

        // Asynchronous reset in the middle of a payload
        send_hdr("R", "D", "M", 1, "rst_hdr");
        apply_row(pl("A", 1), "rst_A");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset", '0, 1'b0);
        hold_len  = 8'd0;
        hold_code = 2'd0;
        @(negedge clk_50M);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_50M);
            e = quiet(r.e);
            e.typ  = 2'd0;
            e.busy = 1'b0;
            check($sformatf("post_reset_%0d", k), e, 1'b0);
        end
        send_hdr("S", "L", "M", 3, "post_rst_msg");
        apply_row(pl("Z", 3), "post_rst_Z");
        apply_row(dn("#", 3, 1), "post_rst_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_msg_parser.md
Name: uart_msg_parser

Overview:
- Receive-side counterpart of the transmit message selector.
- Consumes the byte stream from the UART receiver.
- Frames messages of the form SOF, 3-char type ID, separator, payload, EOF, and decodes the type as RDM, RPM or SLM.
- Streams payload bytes tagged with the decoded type to the downstream RDM/RPM/SLM handlers, and reports message start, completion, length and errors.

Parameters:
- MAX_PAYLOAD, 32: maximum payload bytes per message (1..255).
- TIMEOUT_CYCLES, 500000: idle clocks between bytes before an in-progress message is aborted (10 ms at 50 MHz).
- SOF, 8'h24: start-of-frame byte ('$').
- SEP, 8'h2D: separator after type ID ('-').
- EOF, 8'h23: end-of-frame byte ('#').

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure.
- pl_data  out  8  payload byte.
- pl_valid  out  1  one-cycle strobe per payload byte.
- msg_type  out  2  00 none, 01 RDM, 10 RPM, 11 SLM.
- msg_start  out  1  one-cycle pulse when a valid header (type + separator) completes.
- msg_done  out  1  one-cycle pulse when EOF is accepted.
- msg_len  out  8  payload byte count; updated with msg_done, held until next msg_done.
- msg_err  out  1  one-cycle pulse on abort.
- err_code  out  2  0 framing, 1 bad type, 2 overflow, 3 timeout; updated with msg_err, held otherwise.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State IDLE; all outputs 0, including pl_data, msg_len and err_code.
  - Byte counter and timeout counter cleared.
  - Reset mid-message discards the partial message with no msg_err.
- All outputs are registered. Every response appears exactly 1 cycle after the rx_valid cycle, or after the timeout cycle, that causes it.
- States: IDLE, TYPE0, TYPE1, TYPE2, SEP_WAIT, PAYLOAD.
- IDLE:
  - SOF -> TYPE0.
  - Any other byte is ignored silently: no error, no output.
- TYPE0/TYPE1/TYPE2:
  - Store the byte; advance to the next state.
  - After TYPE2, compare the 3 stored bytes with "RDM", "RPM", "SLM".
  - Match -> SEP_WAIT with the decoded type held internally.
  - No match -> msg_err, err_code=1, go to IDLE.
- SEP_WAIT:
  - SEP -> PAYLOAD. msg_start=1 and msg_type=decoded type in the same cycle; byte counter cleared.
  - Any other non-SOF byte -> msg_err, err_code=0, go to IDLE.
- PAYLOAD:
  - EOF -> msg_done=1, msg_len=count, go to IDLE. Zero-length payload is legal.
  - Any other non-SOF byte with count < MAX_PAYLOAD -> pl_data=byte, pl_valid=1, count+1.
  - Non-SOF, non-EOF byte with count == MAX_PAYLOAD -> msg_err, err_code=2, go to IDLE. Remaining bytes are discarded by IDLE.
- SOF in any non-IDLE state (TYPE0..PAYLOAD):
  - msg_err, err_code=0.
  - Go to TYPE0 (resync); the new frame begins with this byte.
- msg_type:
  - Set at msg_start and held through the msg_done or msg_err cycle.
  - Returns to 00 on the following cycle.
  - Reads 00 during header states.
- Timeout:
  - Counter increments every cycle while busy and rx_valid is low; it clears on rx_valid and in IDLE.
  - On reaching TIMEOUT_CYCLES-1: msg_err, err_code=3, go to IDLE.
  - rx_valid in the same cycle as the terminal count: the byte is processed normally and no timeout is raised.
- msg_done and msg_err are never asserted in the same cycle. pl_valid never coincides with msg_done or msg_err.
- Counter width is clog2(MAX_PAYLOAD+1), zero-extended onto msg_len.

Test Plan:
- "$RPM-AB#" at one byte every 4 cycles -> msg_start with msg_type=10; pl_data 8'h41 then 8'h42 on two pl_valid pulses; msg_done with msg_len=2; msg_type back to 00 the next cycle.
- "$SLM-#" -> msg_start then msg_done with msg_len=0, msg_type=11; no pl_valid.
- "$RXM-" -> msg_err with err_code=1 one cycle after 'M'; the following '-' is ignored in IDLE; busy=0.
- MAX_PAYLOAD=4, "$RDM-12345#" -> 4 pl_valid pulses ('1'..'4'); msg_err with err_code=2 on '5'; '#' ignored; no msg_done.
- "$RDM-AB$SLM-C#" -> msg_err with err_code=0 on the second '$'; then msg_start with type=11, one pl_valid 'C', msg_done with len=1.
- TIMEOUT_CYCLES=16, "$RPM-A" then silence -> msg_err with err_code=3 16 cycles after 'A'. Repeat with the next byte landing on the terminal cycle -> no error. Separately, assert rst_n low mid-payload -> all outputs 0 immediately, no msg_err.
